// File: rtl/hamming_decode_arbiter.sv
// Round-robin share of one Hamming(8,4) SECDED decoder between two codeword requesters.
// Latency: grant at edge N, registered result with out_valid=1 after edge N+1.
// Backpressure: result held in HOLD until out_ready; no new grant is issued meanwhile.

module hamming_decoder (
  input  logic [7:0] code_in,
  output logic [7:0] code_out,
  output logic [1:0] error_flag,
  output logic [2:0] error_location
);
  logic [2:0] syn;
  logic       p_odd;

  // Syndrome over Hamming positions 1..7 (bit i = position i+1), overall parity in bit 7
  always_comb begin
    syn[0]         = code_in[0] ^ code_in[2] ^ code_in[4] ^ code_in[6];
    syn[1]         = code_in[1] ^ code_in[2] ^ code_in[5] ^ code_in[6];
    syn[2]         = code_in[3] ^ code_in[4] ^ code_in[5] ^ code_in[6];
    p_odd          = ^code_in;
    code_out       = code_in;
    error_flag     = 2'b00;
    error_location = syn;
    if (p_odd) begin
      // Single error: odd overall parity; zero syndrome means the overall parity bit flipped
      error_flag = 2'b01;
      if (syn == 3'd0) begin
        code_out[7] = ~code_in[7];
      end else begin
        code_out[syn - 3'd1] = ~code_in[syn - 3'd1];
      end
    end else if (syn != 3'd0) begin
      // Double error: uncorrectable, codeword passed through untouched
      error_flag = 2'b10;
    end
  end
endmodule

module hamming_decode_arbiter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [7:0]       req0_code,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [7:0]       req1_code,
  output logic             req1_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_data,
  output logic [7:0]       out_code,
  output logic [1:0]       out_flag,
  output logic [2:0]       out_loc,
  output logic             out_src,
  input  logic             clr_stats,
  output logic [CNT_W-1:0] sgl_cnt,
  output logic [CNT_W-1:0] dbl_cnt
);
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic       ptr_q;
  logic       src_q;
  logic [7:0] code_q;
  logic       gnt_vld;
  logic       gnt_src;
  logic [7:0] dec_code;
  logic [1:0] dec_flag;
  logic [2:0] dec_loc;

  hamming_decoder u_dec (
    .code_in        (code_q),
    .code_out       (dec_code),
    .error_flag     (dec_flag),
    .error_location (dec_loc)
  );

  // Arbitration, ready strobes and next-state selection
  always_comb begin
    state_d    = state_q;
    gnt_vld    = 1'b0;
    gnt_src    = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state_q)
      IDLE: begin
        gnt_vld = req0_valid | req1_valid;
        gnt_src = (req0_valid && req1_valid) ? ptr_q : req1_valid;
        // Readys stay low while reset is asserted even though the FSM sits in IDLE
        if (gnt_vld && rst_n) begin
          req0_ready = ~gnt_src;
          req1_ready = gnt_src;
          state_d    = DECODE;
        end
      end
      DECODE:  state_d = HOLD;
      HOLD:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Capture the granted word, then register the decoder result and manage out_valid
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q     <= 1'b0;
      src_q     <= 1'b0;
      code_q    <= 8'h00;
      out_valid <= 1'b0;
      out_data  <= 4'h0;
      out_code  <= 8'h00;
      out_flag  <= 2'b00;
      out_loc   <= 3'd0;
      out_src   <= 1'b0;
    end else begin
      if (state_q == IDLE && gnt_vld) begin
        code_q <= gnt_src ? req1_code : req0_code;
        src_q  <= gnt_src;
        ptr_q  <= ~gnt_src;
      end
      if (state_q == DECODE) begin
        out_valid <= 1'b1;
        out_code  <= dec_code;
        out_data  <= {dec_code[6], dec_code[5], dec_code[4], dec_code[2]};
        out_flag  <= dec_flag;
        out_loc   <= dec_loc;
        out_src   <= src_q;
      end
      if (state_q == HOLD && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Saturating error statistics; a clear overrides a same-cycle increment
  always_ff @(posedge clk) begin
    if (!rst_n || clr_stats) begin
      sgl_cnt <= '0;
      dbl_cnt <= '0;
    end else if (state_q == DECODE) begin
      if (dec_flag == 2'b01 && sgl_cnt != {CNT_W{1'b1}}) sgl_cnt <= sgl_cnt + 1'b1;
      if (dec_flag == 2'b10 && dbl_cnt != {CNT_W{1'b1}}) dbl_cnt <= dbl_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_hamming_decode_arbiter.sv
module tb_hamming_decode_arbiter;
  localparam int CNT_W = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic             req0_valid, req1_valid;
  logic [7:0]       req0_code, req1_code;
  logic             req0_ready, req1_ready;
  logic             out_valid, out_ready;
  logic [3:0]       out_data;
  logic [7:0]       out_code;
  logic [1:0]       out_flag;
  logic [2:0]       out_loc;
  logic             out_src;
  logic             clr_stats;
  logic [CNT_W-1:0] sgl_cnt, dbl_cnt;

  int total = 0;
  int bad   = 0;
  int sgl_m = 0;
  int dbl_m = 0;

  hamming_decode_arbiter #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_code(req0_code), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_code(req1_code), .req1_ready(req1_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_code(out_code), .out_flag(out_flag), .out_loc(out_loc), .out_src(out_src),
    .clr_stats(clr_stats), .sgl_cnt(sgl_cnt), .dbl_cnt(dbl_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference SECDED decode: syndrome is the XOR of the positions of all set bits
  function automatic void ref_decode(input logic [7:0] c, output logic [7:0] co,
                                     output logic [1:0] f, output logic [2:0] l);
    int syn;
    syn = 0;
    for (int p = 1; p <= 7; p++) if (c[p-1]) syn = syn ^ p;
    co = c;
    f  = 2'b00;
    l  = syn[2:0];
    if ($countones(c) % 2 == 1) begin
      f = 2'b01;
      if (syn == 0) co[7] = ~co[7];
      else          co[syn-1] = ~co[syn-1];
    end else if (syn != 0) begin
      f = 2'b10;
    end
  endfunction

  function automatic logic [7:0] encode(input logic [3:0] d);
    logic [7:0] c;
    logic       par;
    c = 8'h00;
    c[2] = d[0]; c[4] = d[1]; c[5] = d[2]; c[6] = d[3];
    for (int k = 0; k < 3; k++) begin
      par = 1'b0;
      for (int p = 1; p <= 7; p++) if ((p & (1 << k)) != 0) par = par ^ c[p-1];
      c[(1 << k) - 1] = par;
    end
    c[7] = ^c[6:0];
    return c;
  endfunction

  function automatic logic [3:0] data_of(input logic [7:0] c);
    return {c[6], c[5], c[4], c[2]};
  endfunction

  task automatic count_model(input logic [1:0] f);
    if (f == 2'b01 && sgl_m < CMAX) sgl_m++;
    if (f == 2'b10 && dbl_m < CMAX) dbl_m++;
  endtask

  task automatic clear_stats();
    clr_stats = 1'b1;
    @(posedge clk); #1;
    clr_stats = 1'b0;
    sgl_m = 0;
    dbl_m = 0;
  endtask

  // Drives one word through a requester and returns what the DUT presented; no checking here
  task automatic xfer(input bit who, input logic [7:0] code, output bit tmo, output int lat,
                      output logic [7:0] oc, output logic [3:0] od, output logic [1:0] of,
                      output logic [2:0] ol, output logic os);
    bit got;
    tmo = 1'b0;
    lat = 0;
    if (who) begin req1_valid = 1'b1; req1_code = code; end
    else     begin req0_valid = 1'b1; req0_code = code; end
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if ((who ? req1_ready : req0_ready) === 1'b1) got = 1'b1;
      else begin @(posedge clk); #1; end
    end
    if (!got) tmo = 1'b1;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      if (out_valid === 1'b1) got = 1'b1;
      else begin @(posedge clk); #1; lat++; end
    end
    if (!got) tmo = 1'b1;
    oc = out_code; od = out_data; of = out_flag; ol = out_loc; os = out_src;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1;
    req0_code = 8'h55; req1_code = 8'h51;
    repeat (3) @(posedge clk);
    #1;
    total++; if ({req0_ready, req1_ready} !== 2'b00) begin bad++; $display("FAIL reset_ready got=%b want=00", {req0_ready, req1_ready}); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if ({out_code, out_data, out_flag, out_loc, out_src} !== 18'h0) begin bad++; $display("FAIL reset_outputs got=%h want=0", {out_code, out_data, out_flag, out_loc, out_src}); end
    total++; if ({sgl_cnt, dbl_cnt} !== '0) begin bad++; $display("FAIL reset_counters got=%0d/%0d want=0/0", sgl_cnt, dbl_cnt); end
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst_n = 1'b1;
    sgl_m = 0; dbl_m = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_vectors();
    logic [7:0] tv_in   [4] = '{8'h55, 8'h51, 8'hD5, 8'h56};
    logic [7:0] tv_code [4] = '{8'h55, 8'h55, 8'h55, 8'h56};
    logic [1:0] tv_flag [4] = '{2'b00, 2'b01, 2'b01, 2'b10};
    logic [2:0] tv_loc  [4] = '{3'd0, 3'd3, 3'd0, 3'd3};
    int         tv_sgl  [4] = '{0, 1, 2, 2};
    int         tv_dbl  [4] = '{0, 0, 0, 1};
    bit tmo; int lat; logic [7:0] oc; logic [3:0] od; logic [1:0] of; logic [2:0] ol; logic os;
    for (int i = 0; i < 4; i++) begin
      xfer(i[0], tv_in[i], tmo, lat, oc, od, of, ol, os);
      total++; if (tmo || lat != 1) begin bad++; $display("FAIL vec%0d_latency got=%0d tmo=%0d want=1", i, lat, tmo); end
      total++; if ({oc, od} !== {tv_code[i], 4'hB}) begin bad++; $display("FAIL vec%0d_code got=%h/%h want=%h/b", i, oc, od, tv_code[i]); end
      total++; if ({of, ol, os} !== {tv_flag[i], tv_loc[i], i[0]}) begin bad++; $display("FAIL vec%0d_flag_loc_src got=%b/%0d/%b want=%b/%0d/%b", i, of, ol, os, tv_flag[i], tv_loc[i], i[0]); end
      total++; if (sgl_cnt !== CNT_W'(tv_sgl[i]) || dbl_cnt !== CNT_W'(tv_dbl[i])) begin bad++; $display("FAIL vec%0d_counters got=%0d/%0d want=%0d/%0d", i, sgl_cnt, dbl_cnt, tv_sgl[i], tv_dbl[i]); end
      count_model(tv_flag[i]);
    end
  endtask

  task automatic test_random();
    bit tmo; int lat; logic [7:0] oc; logic [3:0] od; logic [1:0] of; logic [2:0] ol; logic os;
    logic [3:0] d; logic [7:0] c, ec; logic [1:0] ef; logic [2:0] el; bit who;
    int nerr, b1, b2;
    for (int i = 0; i < 40; i++) begin
      if (i % 3 == 0) clear_stats();
      d = 4'($urandom); c = encode(d);
      nerr = $urandom_range(0, 2);
      b1 = $urandom_range(0, 7);
      b2 = (b1 + 1 + $urandom_range(0, 6)) % 8;
      if (nerr >= 1) c[b1] = ~c[b1];
      if (nerr == 2) c[b2] = ~c[b2];
      who = 1'($urandom);
      ref_decode(c, ec, ef, el);
      count_model(ef);
      xfer(who, c, tmo, lat, oc, od, of, ol, os);
      total++; if (tmo || lat != 1) begin bad++; $display("FAIL rnd%0d_latency got=%0d tmo=%0d want=1", i, lat, tmo); end
      total++; if ({oc, od, of, ol, os} !== {ec, data_of(ec), ef, el, who}) begin bad++; $display("FAIL rnd%0d_result in=%h got=%h/%h/%b/%0d/%b want=%h/%h/%b/%0d/%b", i, c, oc, od, of, ol, os, ec, data_of(ec), ef, el, who); end
      if (nerr <= 1) begin
        total++; if (od !== d) begin bad++; $display("FAIL rnd%0d_payload got=%h want=%h", i, od, d); end
      end
      total++; if (sgl_cnt !== CNT_W'(sgl_m) || dbl_cnt !== CNT_W'(dbl_m)) begin bad++; $display("FAIL rnd%0d_counters got=%0d/%0d want=%0d/%0d", i, sgl_cnt, dbl_cnt, sgl_m, dbl_m); end
    end
  endtask

  task automatic test_hold_stall();
    logic [7:0] x, y, snap_c, ec; logic [1:0] snap_f, ef; logic [2:0] el; bit got;
    x = encode(4'($urandom)) ^ 8'h10;
    y = encode(4'($urandom));
    req0_valid = 1'b1; req0_code = x;
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (req0_ready === 1'b1) got = 1'b1; else begin @(posedge clk); #1; end
    end
    total++; if (!got) begin bad++; $display("FAIL stall_grant got=timeout want=ready"); end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b1; req1_code = y;
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (out_valid === 1'b1) got = 1'b1;
    end
    total++; if (!got) begin bad++; $display("FAIL stall_out_valid got=timeout want=1"); end
    ref_decode(x, ec, ef, el);
    count_model(ef);
    snap_c = out_code; snap_f = out_flag;
    total++; if (snap_c !== ec) begin bad++; $display("FAIL stall_code got=%h want=%h", snap_c, ec); end
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || out_code !== snap_c || out_flag !== snap_f || req1_ready !== 1'b0) begin
        bad++; $display("FAIL stall_hold%0d got=v%b c%h r1%b want=v1 c%h r10", n, out_valid, out_code, req1_ready, snap_c);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    total++; if (out_valid !== 1'b0 || req1_ready !== 1'b1) begin bad++; $display("FAIL stall_release got=v%b r1%b want=v0 r11", out_valid, req1_ready); end
    @(posedge clk); #1;
    req1_valid = 1'b0;
    @(posedge clk); #1;
    ref_decode(y, ec, ef, el);
    count_model(ef);
    total++; if (out_valid !== 1'b1 || out_code !== ec || out_src !== 1'b1) begin bad++; $display("FAIL stall_next got=v%b c%h s%b want=v1 c%h s1", out_valid, out_code, out_src, ec); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_stats();
    bit tmo; int lat; logic [7:0] oc; logic [3:0] od; logic [1:0] of; logic [2:0] ol; logic os;
    logic [7:0] c; bit got;
    clear_stats();
    total++; if (sgl_cnt !== '0 || dbl_cnt !== '0) begin bad++; $display("FAIL stats_clear got=%0d/%0d want=0/0", sgl_cnt, dbl_cnt); end
    for (int i = 0; i < 5; i++) begin
      c = encode(4'($urandom));
      c[$urandom_range(0, 7)] ^= 1'b1;
      count_model(2'b01);
      xfer(1'($urandom), c, tmo, lat, oc, od, of, ol, os);
    end
    total++; if (sgl_cnt !== CNT_W'(sgl_m) || sgl_m != 3) begin bad++; $display("FAIL stats_saturate got=%0d want=3", sgl_cnt); end
    c = encode(4'($urandom)) ^ 8'h01;
    req0_valid = 1'b1; req0_code = c;
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (req0_ready === 1'b1) got = 1'b1; else begin @(posedge clk); #1; end
    end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    clr_stats = 1'b1;
    @(posedge clk); #1;
    clr_stats = 1'b0;
    sgl_m = 0; dbl_m = 0;
    total++; if (!got || out_valid !== 1'b1 || out_flag !== 2'b01 || sgl_cnt !== '0) begin bad++; $display("FAIL stats_clr_wins got=v%b f%b sgl%0d want=v1 f01 sgl0", out_valid, out_flag, sgl_cnt); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit tmo; int lat; logic [7:0] oc; logic [3:0] od; logic [1:0] of; logic [2:0] ol; logic os;
    logic [7:0] ec; logic [1:0] ef; logic [2:0] el; bit got; int seen;
    req1_valid = 1'b1; req1_code = encode(4'h6) ^ 8'h20;
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (req1_ready === 1'b1) got = 1'b1; else begin @(posedge clk); #1; end
    end
    @(posedge clk); #1;
    req1_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    total++; if (!got || out_valid !== 1'b0 || sgl_cnt !== '0) begin bad++; $display("FAIL midrst_drop got=v%b sgl%0d want=v0 sgl0", out_valid, sgl_cnt); end
    rst_n = 1'b1;
    sgl_m = 0; dbl_m = 0;
    seen = 0;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL midrst_no_valid got=%0d want=0", seen); end
    @(posedge clk); #1;
    ref_decode(8'h56, ec, ef, el);
    count_model(ef);
    xfer(1'b0, 8'h56, tmo, lat, oc, od, of, ol, os);
    total++; if (tmo || lat != 1 || oc !== ec || of !== ef || dbl_cnt !== CNT_W'(dbl_m)) begin bad++; $display("FAIL midrst_resume got=lat%0d c%h f%b d%0d want=lat1 c%h f%b d%0d", lat, oc, of, dbl_cnt, ec, ef, dbl_m); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] q_code[$]; logic q_src[$];
    logic [7:0] ec; logic [1:0] ef; logic [2:0] el; logic [7:0] pc;
    bit exp_src; bit r0, r1; int g0, g1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    sgl_m = 0; dbl_m = 0;
    exp_src = 1'b0; g0 = 0; g1 = 0;
    req0_code = encode(4'($urandom)); req1_code = encode(4'($urandom));
    req0_valid = 1'b1; req1_valid = 1'b1; out_ready = 1'b1;
    for (int cyc = 0; cyc < 66; cyc++) begin
      @(negedge clk);
      r0 = req0_ready; r1 = req1_ready;
      if (r0 && r1) begin total++; bad++; $display("FAIL b2b_onehot cyc=%0d got=11 want=one-hot", cyc); end
      if (r0 || r1) begin
        total++; if (r1 !== exp_src) begin bad++; $display("FAIL b2b_order cyc=%0d got=%b want=%b", cyc, r1, exp_src); end
        q_code.push_back(r1 ? req1_code : req0_code);
        q_src.push_back(r1);
        exp_src = ~exp_src;
        if (r1) g1++; else g0++;
      end
      if (out_valid === 1'b1) begin
        if (q_code.size() == 0) begin total++; bad++; $display("FAIL b2b_spurious cyc=%0d got=valid want=idle", cyc); end
        else begin
          pc = q_code.pop_front();
          ref_decode(pc, ec, ef, el);
          total++; if (out_code !== ec || out_src !== q_src.pop_front() || out_flag !== ef) begin bad++; $display("FAIL b2b_result cyc=%0d got=%h/%b want=%h", cyc, out_code, out_src, ec); end
        end
      end
      @(posedge clk); #1;
      if (r0) req0_code = encode(4'($urandom));
      if (r1) req1_code = encode(4'($urandom));
      if (cyc >= 58) begin req0_valid = 1'b0; req1_valid = 1'b0; end
    end
    out_ready = 1'b0;
    total++; if (g0 < 8 || g1 < 8 || q_code.size() != 0) begin bad++; $display("FAIL b2b_fairness got=g0 %0d g1 %0d left %0d want>=8/>=8/0", g0, g1, q_code.size()); end
  endtask

  initial begin
    rst_n = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    req0_code = 8'h00; req1_code = 8'h00; out_ready = 1'b0; clr_stats = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_vectors();
    test_random();
    test_hold_stall();
    test_stats();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
